// File: rtl/morph_kernel_lut_if.sv
// AXI-Stream channel that carries kernel coefficients into morph_kernel_lut.
interface morph_kernel_lut_if #(
    parameter int unsigned KERNEL_DATA_WIDTH = 8
);
    logic [KERNEL_DATA_WIDTH-1:0] axis_kernel_tdata;
    logic                         axis_kernel_tvalid;
    logic                         axis_kernel_tready;
    logic                         axis_kernel_tlast;

    modport master (
        output axis_kernel_tdata,
        output axis_kernel_tvalid,
        output axis_kernel_tlast,
        input  axis_kernel_tready
    );

    modport slave (
        input  axis_kernel_tdata,
        input  axis_kernel_tvalid,
        input  axis_kernel_tlast,
        output axis_kernel_tready
    );
endinterface

// File: rtl/morph_kernel_lut.sv
// Double-banked kernel coefficient LUT with two combinational read ports and a streamed shadow load.
// Optional MORPH_KERNEL_LUT_AUTOSWAP_EN: swap one cycle after a complete load instead of waiting for swap_req.
module morph_kernel_lut #(
    parameter int unsigned KERNEL_WIDTH      = 71,
    parameter int unsigned KERNEL_DATA_WIDTH = 8,
    localparam int unsigned ADDR_WIDTH = (KERNEL_WIDTH > 1) ? $clog2(KERNEL_WIDTH) : 1
) (
    input  logic                                clk,
    input  logic                                sreset,
    morph_kernel_lut_if.slave                   axis_kernel,
    input  logic                                swap_req,
    input  logic        [ADDR_WIDTH-1:0]        kernel_lut_address_a,
    output logic signed [KERNEL_DATA_WIDTH-1:0] kernel_lut_data_a,
    input  logic        [ADDR_WIDTH-1:0]        kernel_lut_address_b,
    output logic signed [KERNEL_DATA_WIDTH-1:0] kernel_lut_data_b,
    output logic                                active_bank,
    output logic                                load_pending,
    output logic                                load_error
);

    localparam int unsigned ADDR_EXT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [ADDR_EXT_WIDTH-1:0] DEPTH    = ADDR_EXT_WIDTH'(KERNEL_WIDTH);
    localparam logic [ADDR_WIDTH-1:0]     LAST_IDX = ADDR_WIDTH'(KERNEL_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        ERR_DRAIN = 2'd2,
        PENDING   = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [KERNEL_DATA_WIDTH-1:0] banks [2][KERNEL_WIDTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic                  ready;
    logic                  beat;
    logic                  is_last;
    logic                  wr_en;
    logic                  idx_inc;
    logic                  idx_clr;
    logic                  err_c;
    logic                  swap_c;

    assign axis_kernel.axis_kernel_tready = ready;
    assign beat    = axis_kernel.axis_kernel_tvalid & ready;
    assign is_last = (idx == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (sreset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and load control
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        idx_inc    = 1'b0;
        idx_clr    = 1'b0;
        err_c      = 1'b0;
        swap_c     = 1'b0;
        case (state)
            IDLE, LOAD: begin
                if (beat) begin
                    wr_en = 1'b1;
                    if (is_last && axis_kernel.axis_kernel_tlast) begin
                        state_next = PENDING;
                        idx_clr    = 1'b1;
                    end else if (is_last) begin
                        // Too many beats: flag now, swallow the rest of the packet
                        state_next = ERR_DRAIN;
                        err_c      = 1'b1;
                        idx_clr    = 1'b1;
                    end else if (axis_kernel.axis_kernel_tlast) begin
                        state_next = IDLE;
                        err_c      = 1'b1;
                        idx_clr    = 1'b1;
                    end else begin
                        state_next = LOAD;
                        idx_inc    = 1'b1;
                    end
                end
            end
            ERR_DRAIN: begin
                if (beat && axis_kernel.axis_kernel_tlast) begin
                    state_next = IDLE;
                end
            end
            PENDING: begin
`ifdef MORPH_KERNEL_LUT_AUTOSWAP_EN
                swap_c = 1'b1;
`else
                swap_c = swap_req;
`endif
                if (swap_c) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef MORPH_KERNEL_LUT_AUTOSWAP_EN
    logic unused_swap_req;
    assign unused_swap_req = swap_req;
`endif

    // Banks, index counter and registered status
    always_ff @(posedge clk) begin
        if (sreset) begin
            for (int unsigned i = 0; i < KERNEL_WIDTH; i++) begin
                banks[0][i] <= '0;
                banks[1][i] <= '0;
            end
            idx          <= '0;
            active_bank  <= 1'b0;
            load_pending <= 1'b0;
            load_error   <= 1'b0;
            ready        <= 1'b0;
        end else begin
            if (wr_en) begin
                banks[~active_bank][idx] <= axis_kernel.axis_kernel_tdata;
            end
            if (idx_clr) begin
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + ADDR_WIDTH'(1);
            end
            if (swap_c) begin
                active_bank <= ~active_bank;
            end
            load_pending <= (state_next == PENDING);
            load_error   <= err_c;
            ready        <= (state_next != PENDING);
        end
    end

    // Read ports: out-of-range addresses read the flat (zero) coefficient
    always_comb begin
        kernel_lut_data_a = '0;
        kernel_lut_data_b = '0;
        if ({1'b0, kernel_lut_address_a} < DEPTH) begin
            kernel_lut_data_a = banks[active_bank][kernel_lut_address_a];
        end
        if ({1'b0, kernel_lut_address_b} < DEPTH) begin
            kernel_lut_data_b = banks[active_bank][kernel_lut_address_b];
        end
    end

endmodule

// File: tb/tb_morph_kernel_lut.sv
// Directed bench for morph_kernel_lut: reset, load/swap, malformed loads, backpressure, dual reads.
module tb_morph_kernel_lut;

    logic              clk = 1'b0;
    logic              sreset;
    logic              swap_req;
    logic [6:0]        addr_a;
    logic [6:0]        addr_b;
    logic signed [7:0] data_a;
    logic signed [7:0] data_b;
    logic              active_bank;
    logic              load_pending;
    logic              load_error;

    int total = 0;
    int bad   = 0;

    morph_kernel_lut_if #(.KERNEL_DATA_WIDTH(8)) axis_if ();

    morph_kernel_lut dut (
        .clk                  (clk),
        .sreset               (sreset),
        .axis_kernel          (axis_if.slave),
        .swap_req             (swap_req),
        .kernel_lut_address_a (addr_a),
        .kernel_lut_data_a    (data_a),
        .kernel_lut_address_b (addr_b),
        .kernel_lut_data_b    (data_b),
        .active_bank          (active_bank),
        .load_pending         (load_pending),
        .load_error           (load_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] a;
        logic [6:0] b;
        integer     exp_a;
        integer     exp_b;
    } rd_vec_t;

    rd_vec_t rv [8];

    task automatic check(input string name, input integer act, input integer exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic read_a(input int addr, input integer exp, input string name);
        addr_a = 7'(addr);
        #1;
        check(name, data_a, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input bit last);
        int n;
        bit acc;
        axis_if.axis_kernel_tdata  = 8'(d);
        axis_if.axis_kernel_tvalid = 1'b1;
        axis_if.axis_kernel_tlast  = last;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            acc = (axis_if.axis_kernel_tready === 1'b1);
            step();
            n++;
        end
        axis_if.axis_kernel_tvalid = 1'b0;
        axis_if.axis_kernel_tlast  = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: beat %0d not accepted within 50 cycles", d);
        end
    endtask

    // Ends one edge after PENDING was entered, with the new bank visible
    task automatic do_swap();
`ifdef MORPH_KERNEL_LUT_AUTOSWAP_EN
        step();
`else
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
`endif
    endtask

    initial begin
        sreset   = 1'b1;
        swap_req = 1'b0;
        addr_a   = '0;
        addr_b   = '0;
        axis_if.axis_kernel_tdata  = '0;
        axis_if.axis_kernel_tvalid = 1'b0;
        axis_if.axis_kernel_tlast  = 1'b0;

        // Reset values
        step();
        step();
        check("rst_tready", axis_if.axis_kernel_tready, 0);
        check("rst_active_bank", active_bank, 0);
        check("rst_load_pending", load_pending, 0);
        check("rst_load_error", load_error, 0);
        sreset = 1'b0;
        step();
        check("post_rst_tready", axis_if.axis_kernel_tready, 1);
        for (int i = 0; i < 71; i++) read_a(i, 0, "rst_read");
        read_a(100, 0, "rst_read_oob");

        // Normal load -35..35 then swap
        for (int i = 0; i < 71; i++) send(i - 35, i == 70);
        check("load_pending_set", load_pending, 1);
        check("pending_tready", axis_if.axis_kernel_tready, 0);
        read_a(0, 0, "pre_swap_read0");
        read_a(70, 0, "pre_swap_read70");
        do_swap();
        check("swap1_active_bank", active_bank, 1);
        check("swap1_pending_clear", load_pending, 0);
        read_a(0, -35, "swap1_read0");
        read_a(70, 35, "swap1_read70");

        // Too short: tlast on beat 10
        for (int i = 0; i < 10; i++) send(50, i == 9);
        check("short_err_pulse", load_error, 1);
        check("short_no_pending", load_pending, 0);
        step();
        check("short_err_once", load_error, 0);
        read_a(5, -30, "short_read_unchanged");

        // Too long: 75 beats, tlast on 75th
        for (int i = 0; i < 71; i++) send(100, 1'b0);
        check("long_err_at_71", load_error, 1);
        for (int i = 71; i < 75; i++) send(100, i == 74);
        check("long_err_once", load_error, 0);
        check("long_no_pending", load_pending, 0);
        check("long_drain_tready", axis_if.axis_kernel_tready, 1);

        // swap_req while IDLE
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        step();
        check("idle_swap_ignored", active_bank, 1);
        read_a(70, 35, "idle_swap_read");

        // Good load after malformed ones: 70..0
        for (int i = 0; i < 71; i++) send(70 - i, i == 70);
        check("good_pending", load_pending, 1);
        do_swap();
        check("swap2_active_bank", active_bank, 0);
        read_a(0, 70, "swap2_read0");
        read_a(70, 0, "swap2_read70");
        read_a(35, 35, "swap2_read35");

        // Load 0..70 with a 20-cycle tvalid gap after beat 31
        for (int i = 0; i < 71; i++) begin
            send(i, i == 70);
            if (i == 30) begin
                repeat (20) step();
                check("gap_no_pending", load_pending, 0);
                check("gap_tready", axis_if.axis_kernel_tready, 1);
            end
        end
        check("gap_pending", load_pending, 1);
`ifndef MORPH_KERNEL_LUT_AUTOSWAP_EN
        // Offered beat is not consumed while pending
        axis_if.axis_kernel_tdata  = 8'd99;
        axis_if.axis_kernel_tvalid = 1'b1;
        repeat (3) step();
        check("pend_tready_low", axis_if.axis_kernel_tready, 0);
        check("pend_hold", load_pending, 1);
        check("pend_bank_hold", active_bank, 0);
        axis_if.axis_kernel_tvalid = 1'b0;
`endif
        do_swap();
        check("swap3_active_bank", active_bank, 1);
        read_a(30, 30, "gap_read30");
        read_a(31, 31, "gap_read31");
        read_a(70, 70, "gap_read70");
        step();
        check("after_swap_no_err", load_error, 0);

        // sreset mid-load at beat 40
        for (int i = 0; i < 40; i++) send(i + 1, 1'b0);
        sreset = 1'b1;
        step();
        check("midrst_tready", axis_if.axis_kernel_tready, 0);
        check("midrst_active_bank", active_bank, 0);
        sreset = 1'b0;
        step();
        check("midrst_pending", load_pending, 0);
        read_a(0, 0, "midrst_read0");
        read_a(35, 0, "midrst_read35");
        read_a(70, 0, "midrst_read70");

        // Reload -35..35 and exercise both ports together
        for (int i = 0; i < 71; i++) send(i - 35, i == 70);
        do_swap();
        check("swap4_active_bank", active_bank, 1);

        rv[0] = '{a: 7'd0,   b: 7'd70, exp_a: -35, exp_b: 35};
        rv[1] = '{a: 7'd35,  b: 7'd35, exp_a: 0,   exp_b: 0};
        rv[2] = '{a: 7'd10,  b: 7'd10, exp_a: -25, exp_b: -25};
        rv[3] = '{a: 7'd70,  b: 7'd0,  exp_a: 35,  exp_b: -35};
        rv[4] = '{a: 7'd71,  b: 7'd5,  exp_a: 0,   exp_b: -30};
        rv[5] = '{a: 7'd127, b: 7'd69, exp_a: 0,   exp_b: 34};
        rv[6] = '{a: 7'd1,   b: 7'd2,  exp_a: -34, exp_b: -33};
        rv[7] = '{a: 7'd50,  b: 7'd100, exp_a: 15, exp_b: 0};
        for (int i = 0; i < 8; i++) begin
            addr_a = rv[i].a;
            addr_b = rv[i].b;
            #1;
            check("dual_read_a", data_a, rv[i].exp_a);
            check("dual_read_b", data_b, rv[i].exp_b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
